// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: per-channel request fields, the
// accept/complete pulses and the shared read-data return.
interface mem_arbiter_if #(
  parameter int NUM_CH = 2
) ();
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH-1:0]    req_write;
  logic [NUM_CH-1:0]    req_byte;
  logic [NUM_CH*32-1:0] req_addr;
  logic [NUM_CH*32-1:0] req_wdata;
  logic [NUM_CH-1:0]    req_ready;
  logic [NUM_CH-1:0]    resp_valid;
  logic [31:0]          resp_rdata;
  logic                 busy;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter and access sequencer for one asynchronous SRAM port:
// IDLE -> SETUP -> STROBE x (WAIT_CYCLES+1) -> DONE, with byte-lane handling.
module mem_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1,
  parameter int RR_MODE     = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_data_oe,
  input  logic [31:0]       mem_rdata,
  output logic [3:0]        mem_be_n,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES);
  localparam logic [CH_W-1:0] PTR_RST   = CH_W'(NUM_CH - 1);

  logic [1:0]        state_r;
  logic [3:0]        wait_cnt_r;
  logic [CH_W-1:0]   rr_ptr_r;
  logic [CH_W-1:0]   grant_r;
  logic              write_r;
  logic              byte_r;
  logic [1:0]        lane_r;
  logic [NUM_CH-1:0] resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              busy_r;

  logic [CH_W-1:0]   grant_s;
  logic              found_s;
  logic              accept_s;
  logic [NUM_CH-1:0] req_ready_s;
  logic [NUM_CH-1:0] resp_onehot_s;
  logic [31:0]       sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic              sel_write_s;
  logic              sel_byte_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [7:0]        lane_byte_s;
  logic [31:0]       read_data_s;
  logic              unused_addr_s;

  // Winner search: rotating from pointer+1 in round-robin mode, lowest index otherwise
  always_comb begin
    int               raw;
    logic [CH_W-1:0]  cand;
    logic             hit;
    found_s = 1'b0;
    grant_s = '0;
    raw     = 0;
    cand    = '0;
    hit     = 1'b0;
    if (RR_MODE != 0) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        raw     = int'(rr_ptr_r) + off;
        raw     = (raw >= NUM_CH) ? (raw - NUM_CH) : raw;
        cand    = raw[CH_W-1:0];
        hit     = !found_s && bus.req_valid[cand];
        grant_s = hit ? cand : grant_s;
        found_s = found_s | hit;
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        cand    = i[CH_W-1:0];
        hit     = bus.req_valid[cand];
        grant_s = hit ? cand : grant_s;
        found_s = found_s | hit;
      end
    end
  end

  // Field mux for the winning channel plus byte-lane shaping of enables/data
  always_comb begin
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    sel_write_s = 1'b0;
    sel_byte_s  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_addr_s  = (grant_s == i[CH_W-1:0]) ? bus.req_addr[i*32 +: 32]  : sel_addr_s;
      sel_wdata_s = (grant_s == i[CH_W-1:0]) ? bus.req_wdata[i*32 +: 32] : sel_wdata_s;
      sel_write_s = (grant_s == i[CH_W-1:0]) ? bus.req_write[i]          : sel_write_s;
      sel_byte_s  = (grant_s == i[CH_W-1:0]) ? bus.req_byte[i]           : sel_byte_s;
    end
    be_s    = (sel_write_s && sel_byte_s) ? ~(4'b0001 << sel_addr_s[1:0]) : 4'b0000;
    wdata_s = sel_byte_s ? {4{sel_wdata_s[7:0]}} : sel_wdata_s;
  end

  assign accept_s      = (state_r == IDLE) && found_s && !rst;
  assign req_ready_s   = accept_s ? (NUM_CH'(1) << grant_s) : '0;
  assign resp_onehot_s = NUM_CH'(1) << grant_r;
  assign lane_byte_s   = mem_rdata[{lane_r, 3'b000} +: 8];
  assign read_data_s   = write_r ? 32'h0000_0000
                       : (byte_r ? {24'h00_0000, lane_byte_s} : mem_rdata);
  assign unused_addr_s = ^sel_addr_s[31:ADDR_W+2];

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.busy       = busy_r;

  // Access sequencer; all SRAM strobes are registered so they never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      wait_cnt_r   <= 4'd0;
      rr_ptr_r     <= PTR_RST;
      grant_r      <= '0;
      write_r      <= 1'b0;
      byte_r       <= 1'b0;
      lane_r       <= 2'd0;
      resp_valid_r <= '0;
      resp_rdata_r <= 32'h0000_0000;
      busy_r       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0000_0000;
      mem_data_oe  <= 1'b0;
      mem_be_n     <= 4'b1111;
      mem_ce_n     <= 1'b1;
      mem_oe_n     <= 1'b1;
      mem_we_n     <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= SETUP;
            grant_r     <= grant_s;
            rr_ptr_r    <= grant_s;
            write_r     <= sel_write_s;
            byte_r      <= sel_byte_s;
            lane_r      <= sel_addr_s[1:0];
            busy_r      <= 1'b1;
            mem_addr    <= sel_addr_s[ADDR_W+1:2];
            mem_wdata   <= wdata_s;
            mem_be_n    <= be_s;
            mem_data_oe <= sel_write_s;
            mem_ce_n    <= 1'b0;
          end
        end
        SETUP: begin
          state_r    <= STROBE;
          wait_cnt_r <= 4'd0;
          mem_oe_n   <= write_r;
          mem_we_n   <= !write_r;
        end
        STROBE: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r      <= DONE;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            resp_valid_r <= resp_onehot_s;
            resp_rdata_r <= read_data_s;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        DONE: begin
          // ce_n and data_oe were held through DONE for data hold time
          state_r      <= IDLE;
          resp_valid_r <= '0;
          busy_r       <= 1'b0;
          mem_ce_n     <= 1'b1;
          mem_data_oe  <= 1'b0;
          mem_be_n     <= 4'b1111;
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= '0;
          busy_r       <= 1'b0;
          mem_ce_n     <= 1'b1;
          mem_oe_n     <= 1'b1;
          mem_we_n     <= 1'b1;
          mem_data_oe  <= 1'b0;
          mem_be_n     <= 4'b1111;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority
// instance share the same requester stimulus and SRAM read data.
module tb_mem_arbiter;
  logic        clk;
  logic        rst;
  logic [31:0] mem_rdata;

  mem_arbiter_if #(.NUM_CH(2)) bus_rr ();
  mem_arbiter_if #(.NUM_CH(2)) bus_fp ();

  logic [19:0] rr_addr, fp_addr;
  logic [31:0] rr_wdata, fp_wdata;
  logic        rr_data_oe, fp_data_oe;
  logic [3:0]  rr_be_n, fp_be_n;
  logic        rr_ce_n, rr_oe_n, rr_we_n;
  logic        fp_ce_n, fp_oe_n, fp_we_n;

  assign bus_fp.req_valid = bus_rr.req_valid;
  assign bus_fp.req_write = bus_rr.req_write;
  assign bus_fp.req_byte  = bus_rr.req_byte;
  assign bus_fp.req_addr  = bus_rr.req_addr;
  assign bus_fp.req_wdata = bus_rr.req_wdata;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(20), .WAIT_CYCLES(1), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_rr),
    .mem_addr(rr_addr), .mem_wdata(rr_wdata), .mem_data_oe(rr_data_oe),
    .mem_rdata(mem_rdata), .mem_be_n(rr_be_n),
    .mem_ce_n(rr_ce_n), .mem_oe_n(rr_oe_n), .mem_we_n(rr_we_n)
  );

  mem_arbiter #(.NUM_CH(2), .ADDR_W(20), .WAIT_CYCLES(1), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp),
    .mem_addr(fp_addr), .mem_wdata(fp_wdata), .mem_data_oe(fp_data_oe),
    .mem_rdata(mem_rdata), .mem_be_n(fp_be_n),
    .mem_ce_n(fp_ce_n), .mem_oe_n(fp_oe_n), .mem_we_n(fp_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_g[$];
  int rr_t[$];
  int fp_g[$];
  int fp_t[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus_rr.busy || bus_fp.busy) && n < 30) begin
      adv();
      n++;
    end
    chk(tag, {31'd0, bus_rr.busy | bus_fp.busy}, 32'h0);
  endtask

  // One uncontended access on the round-robin instance, checked cycle by cycle
  task automatic access(input int ch, input logic wr, input logic by,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [19:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_rd);
    int strobe_lo;
    int wrong_lo;
    int oe_bad;
    strobe_lo = 0;
    wrong_lo  = 0;
    oe_bad    = 0;
    bus_rr.req_valid          = 2'b00;
    bus_rr.req_valid[ch]      = 1'b1;
    bus_rr.req_write[ch]      = wr;
    bus_rr.req_byte[ch]       = by;
    bus_rr.req_addr[ch*32 +: 32]  = addr;
    bus_rr.req_wdata[ch*32 +: 32] = wd;
    #1;
    chk("acc_ready", {30'd0, bus_rr.req_ready}, 32'd1 << ch);
    for (int k = 1; k <= 4; k++) begin
      adv();
      if (k == 1) bus_rr.req_valid = 2'b00;
      #1;
      if (k == 1) begin
        chk("acc_addr", {12'd0, rr_addr}, {12'd0, e_addr});
        chk("acc_be_n", {28'd0, rr_be_n}, {28'd0, e_be});
        chk("acc_busy", {31'd0, bus_rr.busy}, 32'd1);
        if (wr) chk("acc_wdata", rr_wdata, e_wd);
      end
      if (rr_ce_n) oe_bad++;
      if (rr_data_oe !== wr) oe_bad++;
      if (wr ? !rr_we_n : !rr_oe_n) strobe_lo++;
      if (wr ? !rr_oe_n : !rr_we_n) wrong_lo++;
      if (k == 4) begin
        chk("acc_resp_v", {30'd0, bus_rr.resp_valid}, 32'd1 << ch);
        chk("acc_rdata", bus_rr.resp_rdata, e_rd);
      end else begin
        chk("acc_no_resp", {30'd0, bus_rr.resp_valid}, 32'd0);
      end
    end
    chk("acc_strobe_n", strobe_lo, 32'd2);
    chk("acc_other_strb", wrong_lo, 32'd0);
    chk("acc_ce_oe", oe_bad, 32'd0);
    adv();
    #1;
    chk("acc_end", {29'd0, bus_rr.resp_valid, rr_ce_n, rr_data_oe}, {29'd0, 2'b00, 1'b1, 1'b0});
    chk("acc_idle", {31'd0, bus_rr.busy}, 32'd0);
  endtask

  initial begin
    int rdy_busy;
    int exp_rr[4];
    rst                 = 1'b1;
    mem_rdata           = 32'h0000_0000;
    bus_rr.req_valid    = 2'b11;
    bus_rr.req_write    = 2'b00;
    bus_rr.req_byte     = 2'b00;
    bus_rr.req_addr     = 64'd0;
    bus_rr.req_wdata    = 64'd0;

    // Reset held two cycles with both channels requesting
    adv();
    #1;
    chk("rst_ready", {30'd0, bus_rr.req_ready}, 32'd0);
    chk("rst_strobes", {24'd0, rr_ce_n, rr_oe_n, rr_we_n, rr_be_n, rr_data_oe}, 32'h0000_00FE);
    chk("rst_addr", {12'd0, rr_addr}, 32'd0);
    chk("rst_wdata", rr_wdata, 32'd0);
    chk("rst_resp", {29'd0, bus_rr.busy, bus_rr.resp_valid}, 32'd0);
    chk("rst_rdata", bus_rr.resp_rdata, 32'd0);
    adv();
    #1;
    chk("rst_ready2", {28'd0, bus_rr.req_ready, bus_fp.req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_first_rr", {30'd0, bus_rr.req_ready}, 32'd1);
    chk("rst_first_fp", {30'd0, bus_fp.req_ready}, 32'd1);
    adv();
    bus_rr.req_valid = 2'b00;
    wait_idle("drain_rst");

    // Directed single accesses; the last one leaves the RR pointer on ch1
    mem_rdata = 32'hDEAD_BEEF;
    access(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 20'h00004, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    mem_rdata = 32'h1122_3344;
    access(0, 1'b0, 1'b1, 32'h0000_0022, 32'h0, 20'h00008, 4'b0000, 32'h0, 32'h0000_0022);
    access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 20'h00010, 4'b0000, 32'h1234_5678, 32'h0);
    access(0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_FF3C, 20'h00001, 4'b1110, 32'h3C3C_3C3C, 32'h0);
    access(1, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_00A5, 20'h00004, 4'b0111, 32'hA5A5_A5A5, 32'h0);

    // Contention: both channels hold requests for four grants
    bus_rr.req_write = 2'b00;
    bus_rr.req_byte  = 2'b00;
    bus_rr.req_valid = 2'b11;
    rdy_busy = 0;
    for (int cyc = 0; cyc < 60 && (rr_g.size() < 4 || fp_g.size() < 4); cyc++) begin
      #1;
      if (bus_rr.req_ready != 2'b00) begin
        rr_g.push_back(bus_rr.req_ready == 2'b10 ? 1 : 0);
        rr_t.push_back(cyc);
        if (bus_rr.busy) rdy_busy++;
      end
      if (bus_fp.req_ready != 2'b00) begin
        fp_g.push_back(bus_fp.req_ready == 2'b10 ? 1 : 0);
        fp_t.push_back(cyc);
      end
      adv();
    end
    bus_rr.req_valid = 2'b00;
    wait_idle("drain_cont");
    chk("rr_count", rr_g.size(), 32'd4);
    chk("fp_count", fp_g.size(), 32'd4);
    chk("rdy_busy", rdy_busy, 32'd0);
    exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0; exp_rr[3] = 1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", (i < rr_g.size()) ? rr_g[i] : -1, exp_rr[i]);
      chk("fp_grant", (i < fp_g.size()) ? fp_g[i] : -1, 32'd0);
      if (i > 0) begin
        chk("rr_spacing", (i < rr_t.size()) ? rr_t[i] - rr_t[i-1] : -1, 32'd5);
        chk("fp_spacing", (i < fp_t.size()) ? fp_t[i] - fp_t[i-1] : -1, 32'd5);
      end
    end

    // Abort: reset lands in the second strobe cycle of a write
    bus_rr.req_write[0]      = 1'b1;
    bus_rr.req_byte[0]       = 1'b0;
    bus_rr.req_addr[31:0]    = 32'h0000_0008;
    bus_rr.req_wdata[31:0]   = 32'h55AA_55AA;
    bus_rr.req_valid         = 2'b01;
    #1;
    chk("abort_ready", {30'd0, bus_rr.req_ready}, 32'd1);
    adv();
    bus_rr.req_valid = 2'b00;
    adv();
    adv();
    #1;
    chk("abort_we_low", {31'd0, rr_we_n}, 32'd0);
    rst = 1'b1;
    adv();
    #1;
    chk("abort_strobes", {24'd0, rr_ce_n, rr_oe_n, rr_we_n, rr_be_n, rr_data_oe}, 32'h0000_00FE);
    chk("abort_busy", {31'd0, bus_rr.busy}, 32'd0);
    chk("abort_noresp", {30'd0, bus_rr.resp_valid}, 32'd0);
    rst = 1'b0;
    adv();
    #1;
    chk("abort_noresp2", {30'd0, bus_rr.resp_valid}, 32'd0);
    mem_rdata = 32'hCAFE_F00D;
    access(1, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 20'h00003, 4'b0000, 32'h0, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter and sequencer for one asynchronous SRAM port (BaseRAM/ExtRAM style).
- Generalises the existing single-port IF/MEM mux to NUM_CH requesters, e.g. IF, MEM, and later DMA or debug.
- Adds fixed or round-robin priority, programmable wait states, byte-lane writes, byte-extracted reads, and explicit valid/ready handshakes in place of bubble-count stalling.

Parameters:
- NUM_CH, 2: number of requester channels (1..8).
- ADDR_W, 20: SRAM word-address width.
- WAIT_CYCLES, 1: extra strobe cycles beyond the minimum one (0..15).
- RR_MODE, 1: 1 selects round-robin arbitration; 0 selects fixed priority, with ch0 highest.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_CH  per-channel request present.
- req_write  in  NUM_CH  1 = write, 0 = read.
- req_byte  in  NUM_CH  1 = byte access, 0 = word access.
- req_addr  in  NUM_CH*32  byte addresses; channel i occupies [32i+31:32i].
- req_wdata  in  NUM_CH*32  write data; for byte writes only bits [7:0] are used.
- req_ready  out  NUM_CH  one-hot accept pulse.
- resp_valid  out  NUM_CH  one-hot completion pulse.
- resp_rdata  out  32  read data, shared by all channels; valid only with resp_valid.
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2].
- mem_wdata  out  32  data to SRAM.
- mem_data_oe  out  1  tristate enable for mem_wdata (tristate buffer lives outside this block).
- mem_rdata  in  32  data from SRAM.
- mem_be_n  out  4  byte enables, active-low.
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  chip select, output enable, write enable; all active-low.

Behaviour:
- Reset values:
  - State is IDLE.
  - req_ready = 0, resp_valid = 0, resp_rdata = 0, busy = 0.
  - mem_ce_n = mem_oe_n = mem_we_n = 1, mem_be_n = 4'b1111, mem_data_oe = 0.
  - mem_addr = 0, mem_wdata = 0.
  - RR pointer = NUM_CH-1, so ch0 wins the first contention.
- Reset mid-operation: the next cycle is IDLE with all strobes deasserted; the aborted request gets no resp_valid.
- FSM states: IDLE -> SETUP -> STROBE (WAIT_CYCLES+1 cycles) -> DONE -> IDLE.
- IDLE:
  - If any req_valid is high, the winner g gets combinational req_ready[g] = 1 in that cycle (cycle T).
  - addr, write, byte and wdata of channel g are latched at the T edge; go to SETUP.
  - If no request is present, stay in IDLE.
- SETUP (T+1):
  - mem_ce_n = 0; mem_addr and mem_be_n are driven.
  - mem_oe_n = mem_we_n = 1.
  - For writes, mem_data_oe = 1.
- STROBE (T+2 .. T+2+WAIT_CYCLES):
  - A wait counter counts 0..WAIT_CYCLES.
  - Reads: mem_oe_n = 0. Writes: mem_we_n = 0.
  - For reads, mem_rdata is captured at the edge ending the last STROBE cycle.
- DONE (T+WAIT_CYCLES+3):
  - mem_oe_n = mem_we_n = 1; mem_ce_n = 0 and mem_data_oe are held for data hold time.
  - resp_valid[g] = 1 for exactly one cycle; resp_rdata is valid (reads only; 0 for writes).
  - Go to IDLE.
- Latency and throughput:
  - Accept to response is WAIT_CYCLES+3 cycles.
  - One access completes per WAIT_CYCLES+4 cycles.
  - No acceptance happens outside IDLE; req_ready is 0 while busy.
- Requester handshake rules:
  - A requester holds req_valid and its fields stable until req_ready.
  - Fields may change from the cycle after acceptance.
  - A requester may deassert req_valid before acceptance (the request is withdrawn).
- Byte lanes are little-endian; lane k is bits [8k+7:8k], lane = addr[1:0].
  - Word access: mem_be_n = 0000, mem_wdata = wdata, and addr[1:0] is ignored.
  - Byte write: mem_be_n has 0 only on the lane bit; mem_wdata = wdata[7:0] replicated to all 4 lanes.
  - Byte read: mem_be_n = 0000; resp_rdata = {24'b0, selected lane}. Sign extension is the requester's job.
- Arbitration:
  - Fixed priority: the lowest asserted index wins.
  - Round-robin: search starts at pointer+1 mod NUM_CH. The pointer updates to g only on acceptance.
  - Requests that arrive or stay valid during a busy access wait; no request is lost.
- NUM_CH = 1: arbitration degenerates to req_ready = req_valid & idle.

Test Plan:
- Reset: hold rst 2 cycles with req_valid = 2'b11 -> all outputs at reset values, no req_ready while rst is high, ch0 granted in the first IDLE cycle after rst falls.
- Word read: ch0, addr 0x00000010, WAIT_CYCLES = 1, mem_rdata = 0xDEADBEEF -> req_ready[0] at T, mem_addr = 0x00004 at T+1, mem_oe_n low T+2..T+3, resp_valid[0] at T+4 with resp_rdata = 0xDEADBEEF.
- Byte write: ch1, addr 0x00000013, wdata 0x000000A5 -> mem_be_n = 4'b0111, mem_wdata = 0xA5A5A5A5, mem_we_n low exactly 2 cycles, mem_data_oe high SETUP..DONE, resp_valid[1] with resp_rdata = 0.
- Byte read: addr 0x00000022, mem_rdata = 0x11223344 -> mem_addr = 0x00008, resp_rdata = 0x00000022.
- Contention: both channels hold req_valid for 4 accesses -> RR_MODE = 1 grants 0,1,0,1; RR_MODE = 0 grants 0,0,0,0; each grant is spaced WAIT_CYCLES+4 cycles apart.
- Abort: assert rst during the second STROBE cycle of a write -> next cycle IDLE, mem_we_n = 1, mem_ce_n = 1, no resp_valid for that request; a new request is accepted normally afterwards.
